uart_tx_feeder: RTL and testbench

Byte buffer and flow-control stage directly upstream of the `uart` transmitter. It accepts bytes from the host side with a valid/ready handshake and stores them in a synchronous FIFO. It then drains them one at a time into the `uart` `din`/`wr_en` inputs, pacing each transfer on the transmitter's `tx_busy`. It removes the need for the host to single-step the UART with hand-timed `wr_en` pulses.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_feeder_if.sv | 12 +
 rtl/uart_sync_fifo.sv | 85 ++++++++
 rtl/uart_tx_feeder.sv | 137 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit-side blocks.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host-side byte handshake into uart_tx_feeder (valid/ready, push on valid && ready).
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and a registered read port.
// The occupancy counter exists only when UART_TX_FEEDER_LEVEL_EN is defined.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic                   full,
  output logic                   empty,
  output logic                   push_drop
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic [UART_DATA_W-1:0] pop_data_reg;
  logic                   do_push;
  logic                   do_pop;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // A pop frees the head slot in the same edge, so a push against a full
  // FIFO is still taken when it coincides with a pop.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;

  assign pop_data = pop_data_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // The read register doubles as the holding register for the popped byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pop_data_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [AW:0] level_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign level = level_reg;
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and drains them into the uart transmitter, pacing on tx_busy.
// Defining UART_TX_FEEDER_LEVEL_EN adds the FIFO occupancy output 'level'.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_feeder_if.slave        wr_if,
  input  logic                   ovf_clr,
  output logic [UART_DATA_W-1:0] uart_din,
  output logic                   uart_wr_en,
  input  logic                   uart_tx_busy,
  output logic                   empty,
  output logic                   overflow,
  output logic                   tx_timeout
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int                CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  feeder_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             uart_wr_en_reg;
  logic             overflow_reg;
  logic             tx_timeout_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push_drop;
  logic             timeout_set;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_if.wr_valid),
    .push_data (wr_if.wr_data),
    .pop       (fifo_pop),
    .pop_data  (uart_din),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (push_drop)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  assign wr_if.wr_ready = ~fifo_full;
  assign empty          = fifo_empty;
  assign uart_wr_en     = uart_wr_en_reg;
  assign overflow       = overflow_reg;
  assign tx_timeout     = tx_timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      uart_wr_en_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      uart_wr_en_reg <= (state_reg == ISSUE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    fifo_pop    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!fifo_empty && !uart_tx_busy) begin
          fifo_pop   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        // Leaving WAIT_DONE performs the IDLE decision in the same cycle so the
        // next pulse lands two cycles after tx_busy falls.
        if (!uart_tx_busy) begin
          cnt_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg   <= 1'b0;
      tx_timeout_reg <= 1'b0;
    end else begin
      if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end else if (push_drop) begin
        overflow_reg <= 1'b1;
      end
      if (ovf_clr) begin
        tx_timeout_reg <= 1'b0;
      end else if (timeout_set) begin
        tx_timeout_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder with a small uart busy model.
// Build with UART_TX_FEEDER_LEVEL_EN defined to also check the level output.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [7:0] uart_din;
  logic       uart_wr_en;
  logic       uart_tx_busy = 1'b0;
  logic       empty;
  logic       overflow;
  logic       tx_timeout;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_tx_feeder_if wr_if ();

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_if        (wr_if),
    .ovf_clr      (ovf_clr),
    .uart_din     (uart_din),
    .uart_wr_en   (uart_wr_en),
    .uart_tx_busy (uart_tx_busy),
    .empty        (empty),
    .overflow     (overflow),
    .tx_timeout   (tx_timeout)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .level        (level)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // uart model: busy rises the edge after wr_en and stays high busy_len cycles
  bit mode_hold_high = 1'b0;
  bit mode_never     = 1'b0;
  int busy_len       = 4;
  int busy_cnt       = 0;

  always @(posedge clk) begin
    if (mode_hold_high) begin
      uart_tx_busy <= 1'b1;
    end else if (mode_never) begin
      uart_tx_busy <= 1'b0;
    end else if (uart_wr_en) begin
      uart_tx_busy <= 1'b1;
      busy_cnt     <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt     <= 0;
      uart_tx_busy <= 1'b0;
    end
  end

  // every transmitted byte and the cycle its start pulse was seen
  logic [7:0] got_q[$];
  int         pulse_q[$];

  always @(negedge clk) begin
    if (uart_wr_en) begin
      got_q.push_back(uart_din);
      pulse_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    tick(1);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    pulse_q.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget, input int settle);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(settle);
    check("pulse_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_din"},      32'(uart_din), 32'h00);
    check({tag, "_wr_en"},    32'(uart_wr_en), 32'h0);
    check({tag, "_wr_ready"}, 32'(wr_if.wr_ready), 32'h1);
    check({tag, "_empty"},    32'(empty), 32'h1);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_timeout"},  32'(tx_timeout), 32'h0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check({tag, "_level"},    32'(level), 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         e;
    int         p0;
    int         n;

    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;

    // reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check_reset_state("reset");

    // single byte: pulse two edges after the push edge
    busy_len = 20;
    clear_mon();
    push_byte(8'hA5);
    e = cyc;
    check("a5_empty_after_push", 32'(empty), 32'h0);
    tick(30);
    check("a5_count", 32'(got_q.size()), 32'd1);
    check("a5_din", 32'(got_q[0]), 32'hA5);
    check("a5_pulse_cycle", 32'(pulse_q[0]), 32'(e + 2));
    check("a5_din_hold", 32'(uart_din), 32'hA5);
    check("a5_empty_end", 32'(empty), 32'h1);

    // fill with 00..0F while busy, overflow on the 17th, drain in order
    mode_hold_high = 1'b1;
    tick(2);
    clear_mon();
    exp_q.delete();
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_if.wr_data = 8'(i);
      check("fill_ready", 32'(wr_if.wr_ready), 32'h1);
      tick(1);
      exp_q.push_back(8'(i));
    end
    check("full_ready_low", 32'(wr_if.wr_ready), 32'h0);
    check("full_no_ovf_yet", 32'(overflow), 32'h0);
    wr_if.wr_data = 8'h10;
    tick(1);
    wr_if.wr_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'h1);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("full_level", 32'(level), 32'd16);
`endif
    busy_len = 1;
    mode_hold_high = 1'b0;
    wait_pulses(DEPTH, 400, 20);
    for (int i = 0; i < DEPTH; i++) begin
      check("order_byte", 32'(got_q[i]), 32'(exp_q[i]));
    end
    for (int i = 1; i < DEPTH; i++) begin
      check("min_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'd4);
    end
    check("drain_empty", 32'(empty), 32'h1);
    check("ovf_sticky", 32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // push and pop on the same edge with the FIFO full
    mode_hold_high = 1'b1;
    tick(2);
    clear_mon();
    exp_q.delete();
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_if.wr_data = b;
      tick(1);
      exp_q.push_back(b);
    end
    wr_if.wr_data = 8'($urandom_range(0, 255));
    tick(1);
    wr_if.wr_valid = 1'b0;
    check("sim_ovf_set", 32'(overflow), 32'h1);
    busy_len = 1;
    mode_hold_high = 1'b0;
    tick(1);
    b = 8'($urandom_range(0, 255));
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    tick(1);
    wr_if.wr_valid = 1'b0;
    exp_q.push_back(b);
    check("sim_pop_head", 32'(uart_din), 32'(exp_q[0]));
    check("sim_still_full", 32'(wr_if.wr_ready), 32'h0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("sim_level", 32'(level), 32'd16);
`endif
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("sim_ovf_clr", 32'(overflow), 32'h0);
    wait_pulses(DEPTH + 1, 400, 20);
    for (int i = 0; i <= DEPTH; i++) begin
      check("sim_order", 32'(got_q[i]), 32'(exp_q[i]));
    end

    // busy never rises: timeout after BUSY_TIMEOUT cycles, next byte still goes
    mode_never = 1'b1;
    clear_mon();
    push_byte(8'h3C);
    e = cyc;
    tick(BUSY_TIMEOUT + 1);
    check("to_not_yet", 32'(tx_timeout), 32'h0);
    tick(1);
    check("to_set", 32'(tx_timeout), 32'h1);
    check("to_byte", 32'(got_q[0]), 32'h3C);
    check("to_pulse_cycle", 32'(pulse_q[0]), 32'(e + 2));
    mode_never = 1'b0;
    busy_len = 2;
    b = 8'($urandom_range(0, 255));
    push_byte(b);
    wait_pulses(2, 100, 10);
    check("to_next_byte", 32'(got_q[1]), 32'(b));
    check("to_sticky", 32'(tx_timeout), 32'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("to_cleared", 32'(tx_timeout), 32'h0);

    // push 0xCE while the previous byte is still transmitting
    busy_len = 12;
    clear_mon();
    b = 8'($urandom_range(0, 255));
    push_byte(b);
    e = cyc;
    tick(4);
    push_byte(8'hCE);
    wait_pulses(2, 100, 20);
    p0 = pulse_q[0];
    check("ce_first_pulse", 32'(p0), 32'(e + 2));
    check("ce_first_byte", 32'(got_q[0]), 32'(b));
    // busy falls at p0 + 1 + busy_len; next pulse two cycles later
    check("ce_pulse_cycle", 32'(pulse_q[1]), 32'(p0 + 1 + 12 + 2));
    check("ce_byte", 32'(got_q[1]), 32'hCE);

    // randomized rounds, never more than DEPTH bytes outstanding
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      exp_q.delete();
      busy_len = $urandom_range(1, 6);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        tick($urandom_range(0, 3));
        b = 8'($urandom_range(0, 255));
        check("rnd_ready", 32'(wr_if.wr_ready), 32'h1);
        push_byte(b);
        exp_q.push_back(b);
      end
      wait_pulses(n, 20 * n + 50, 20);
      for (int i = 0; i < n; i++) begin
        check("rnd_byte", 32'(got_q[i]), 32'(exp_q[i]));
      end
      for (int i = 1; i < n; i++) begin
        check("rnd_spacing_ge4", 32'(pulse_q[i] - pulse_q[i-1] >= 4), 32'h1);
      end
    end

    // reset during WAIT_DONE with five bytes queued
    busy_len = 30;
    clear_mon();
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_if.wr_data = 8'($urandom_range(0, 255));
      tick(1);
      if (i == 0) e = cyc;
    end
    wr_if.wr_valid = 1'b0;
    tick(e + 10 - cyc);
    check("rst_one_sent", 32'(got_q.size()), 32'd1);
    check("rst_queued", 32'(empty), 32'h0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_reset_state("midreset");
    tick(60);
    check("rst_no_more_pulses", 32'(got_q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
